// File: rtl/ft245_pkg.sv
// Shared types and default timing for the FT245 pin-side bridge.
package ft245_pkg;

   localparam int BYTE_W          = 8;
   localparam int DEF_FIFO_DEPTH  = 16;
   localparam int DEF_STROBE_CYC  = 4;
   localparam int DEF_RECOVER_CYC = 6;

   typedef enum logic [2:0] {
      IDLE,
      RD_STB,
      RD_REC,
      WR_SETUP,
      WR_STB,
      WR_HOLD,
      WR_REC
   } ft245_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Fall-through byte FIFO with extra-MSB pointers; push on full and pop on empty are ignored.
module byte_fifo
   import ft245_pkg::*;
#(
   parameter  int DEPTH = DEF_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   output logic [BYTE_W-1:0] pop_data,
   output logic [AW:0]       level
);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              full;
   logic              empty;
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];
   assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/ft245_bridge.sv
// FT245 async FIFO pin controller: flag synchronisers, strobe FSM and two byte FIFOs.
// Optional build macro FT245_LOOPBACK_EN adds a loopback input that echoes host bytes back.
module ft245_bridge
   import ft245_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int STROBE_CYC  = DEF_STROBE_CYC,
   parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
   input  logic              clk,
   input  logic              reset,
`ifdef FT245_LOOPBACK_EN
   input  logic              loopback,
`endif
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [BYTE_W-1:0] pin_data_i,
   output logic [BYTE_W-1:0] pin_data_o,
   output logic              pin_data_oe,
   input  logic              pin_rxf_n,
   input  logic              pin_txe_n,
   output logic              pin_rd_n,
   output logic              pin_wr_n
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (STROBE_CYC > RECOVER_CYC) ? STROBE_CYC : RECOVER_CYC;
   localparam int CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] STB_LOAD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] REC_LOAD = CW'(RECOVER_CYC - 1);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

   ft245_state_t      state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [1:0]        rxf_sync, txe_sync;
   logic              rxf_s, txe_s;
   logic              prio_rx;
   logic              serve_rd, capture, rd_push;
   logic [BYTE_W-1:0] rd_byte;
   logic              rd_ok, wr_ok;
   logic              tx_push, tx_pop, rx_push, rx_pop;
   logic [BYTE_W-1:0] tx_push_data, tx_head, rx_head;
   logic [AW:0]       tx_level, rx_level;
   logic              tx_full, tx_empty, rx_full, rx_empty;

   // Host flags are asynchronous; reset to "not ready" so nothing starts during reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxf_sync <= 2'b11;
         txe_sync <= 2'b11;
      end else begin
         rxf_sync <= {rxf_sync[0], pin_rxf_n};
         txe_sync <= {txe_sync[0], pin_txe_n};
      end
   end
   assign rxf_s = rxf_sync[1];
   assign txe_s = txe_sync[1];

   assign tx_full  = (tx_level == FULL_LVL);
   assign tx_empty = (tx_level == '0);
   assign rx_full  = (rx_level == FULL_LVL);
   assign rx_empty = (rx_level == '0);
   assign wr_ok    = !txe_s && !tx_empty;
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_data  = rx_head;

`ifdef FT245_LOOPBACK_EN
   logic lb_q, lb_act;

   // Mode is only taken from the pin while idle so a transfer never changes routing mid-flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              lb_q <= 1'b0;
      else if (state == IDLE) lb_q <= loopback;
   end
   assign lb_act       = (state == IDLE) ? loopback : lb_q;
   assign rd_ok        = !rxf_s && (lb_act ? !tx_full : !rx_full);
   assign tx_ready     = !tx_full && !lb_act;
   assign rx_valid     = !rx_empty && !lb_act;
   assign tx_push      = (tx_valid && tx_ready) || (rd_push && lb_act);
   assign tx_push_data = lb_act ? rd_byte : tx_data;
   assign rx_push      = rd_push && !lb_act;
`else
   assign rd_ok        = !rxf_s && !rx_full;
   assign tx_ready     = !tx_full;
   assign rx_valid     = !rx_empty;
   assign tx_push      = tx_valid && tx_ready;
   assign tx_push_data = tx_data;
   assign rx_push      = rd_push;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tx_pop   = 1'b0;
      capture  = 1'b0;
      serve_rd = 1'b0;
      case (state)
         IDLE: begin
            if (rd_ok && (!wr_ok || prio_rx)) begin
               state_nx = RD_STB;
               cnt_nx   = STB_LOAD;
               serve_rd = 1'b1;
            end else if (wr_ok) begin
               state_nx = WR_SETUP;
               tx_pop   = 1'b1;
            end
         end
         RD_STB: begin
            if (cnt == '0) begin
               state_nx = RD_REC;
               cnt_nx   = REC_LOAD;
               capture  = 1'b1;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         WR_SETUP: begin
            state_nx = WR_STB;
            cnt_nx   = STB_LOAD;
         end
         WR_STB: begin
            if (cnt == '0) state_nx = WR_HOLD;
            else           cnt_nx   = cnt - 1'b1;
         end
         WR_HOLD: begin
            state_nx = WR_REC;
            cnt_nx   = REC_LOAD;
         end
         RD_REC, WR_REC: begin
            if (cnt == '0) state_nx = IDLE;
            else           cnt_nx   = cnt - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Pin outputs are registered from the next state so strobes are glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         prio_rx     <= 1'b1;
         rd_push     <= 1'b0;
         pin_rd_n    <= 1'b1;
         pin_wr_n    <= 1'b1;
         pin_data_oe <= 1'b0;
         pin_data_o  <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         rd_push     <= capture;
         pin_rd_n    <= (state_nx != RD_STB);
         pin_wr_n    <= (state_nx != WR_STB);
         pin_data_oe <= (state_nx == WR_SETUP) || (state_nx == WR_STB) || (state_nx == WR_HOLD);
         if (tx_pop)        pin_data_o <= tx_head;
         if (serve_rd)      prio_rx    <= 1'b0;
         else if (tx_pop)   prio_rx    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) rd_byte <= pin_data_i;
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .level     (tx_level)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rd_byte),
      .pop       (rx_pop),
      .pop_data  (rx_head),
      .level     (rx_level)
   );

endmodule

// File: tb/tb_ft245_bridge.sv
// Directed bench for ft245_bridge with a simple FT245 host model and pin-protocol monitor.
module tb_ft245_bridge;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] pin_data_i = 8'h00;
   logic [7:0] pin_data_o;
   logic       pin_data_oe;
   logic       rxf_n = 1'b1;
   logic       txe_n = 1'b1;
   logic       rd_n;
   logic       wr_n;
`ifdef FT245_LOOPBACK_EN
   logic       loopback = 1'b0;
`endif

   ft245_bridge dut (
      .clk         (clk),
      .reset       (reset),
`ifdef FT245_LOOPBACK_EN
      .loopback    (loopback),
`endif
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .pin_data_i  (pin_data_i),
      .pin_data_o  (pin_data_o),
      .pin_data_oe (pin_data_oe),
      .pin_rxf_n   (rxf_n),
      .pin_txe_n   (txe_n),
      .pin_rd_n    (rd_n),
      .pin_wr_n    (wr_n)
   );

   always #5 clk = ~clk;

   logic [7:0] host_q [$];
   logic [7:0] wr_log [$];
   logic [7:0] seq [$];
   int         reads = 0;
   int         viol = 0;
   int         n_vec = 0;
   int         n_err = 0;

   // Host: offers the head of host_q while non-empty, consumes it on RD# rising.
   always @(negedge clk) begin
      rxf_n      = (host_q.size() == 0);
      pin_data_i = (host_q.size() != 0) ? host_q[0] : 8'h00;
   end
   always @(posedge rd_n) if (!reset) begin
      if (host_q.size() != 0) void'(host_q.pop_front());
      reads++;
   end
   always @(negedge rd_n) if (!reset) seq.push_back("R");
   always @(negedge wr_n) if (!reset) seq.push_back("W");
   always @(posedge wr_n) if (!reset) wr_log.push_back(pin_data_o);

   logic       prev_oe = 1'b0, prev_wr = 1'b1, drop_pending = 1'b0;
   logic [7:0] prev_do = 8'h00;
   always @(negedge clk) begin
      if (reset) begin
         prev_oe = 1'b0; prev_wr = 1'b1; drop_pending = 1'b0;
      end else begin
         if (!rd_n && pin_data_oe) viol++;
         if (!wr_n && !pin_data_oe) viol++;
         if (prev_wr && !wr_n && !prev_oe) viol++;
         if (pin_data_oe && prev_oe && pin_data_o !== prev_do) viol++;
         if (drop_pending && pin_data_oe) viol++;
         drop_pending = 1'b0;
         if (!prev_wr && wr_n) begin
            if (!pin_data_oe) viol++;
            drop_pending = 1'b1;
         end
         prev_oe = pin_data_oe; prev_wr = wr_n; prev_do = pin_data_o;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] logv(input int i);
      return (wr_log.size() > i) ? {24'h0, wr_log[i]} : 32'hDEAD;
   endfunction

   task automatic pop_rx(input string tag, input logic [7:0] exp);
      int i = 0;
      @(negedge clk);
      while (!rx_valid && i < 100) begin @(negedge clk); i++; end
      chk(tag, rx_valid ? {24'h0, rx_data} : 32'hDEAD, {24'h0, exp});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b);
      int i = 0;
      @(negedge clk);
      while (!tx_ready && i < 100) begin @(negedge clk); i++; end
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_wr(input int n, input int max);
      int i = 0;
      while (wr_log.size() < n && i < max) begin @(negedge clk); i++; end
   endtask

   task automatic count_rd_n(input logic level, output int len);
      len = 1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (rd_n !== level) break;
         len++;
      end
   endtask

   initial begin
      int n, len, gap, base, i;

      // Reset with both host flags asserted and empty FIFOs
      host_q = '{8'h5A, 8'hA5};
      txe_n  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rd_n", rd_n, 1);
      chk("rst_wr_n", wr_n, 1);
      chk("rst_oe", pin_data_oe, 0);
      chk("rst_data_o", pin_data_o, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_ready", tx_ready, 1);
      reset = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (rd_n && n < 10);
      chk("rd_fall_latency", n, 3);
      chk("wr_idle", wr_n, 1);

      // Two host bytes: strobe widths, recovery gap, order
      count_rd_n(1'b0, len);
      chk("rd0_len", len, 4);
      count_rd_n(1'b1, gap);
      chk("rd_gap_ge6", gap >= 6, 1);
      count_rd_n(1'b0, len);
      chk("rd1_len", len, 4);
      pop_rx("rx_5a", 8'h5A);
      pop_rx("rx_a5", 8'hA5);

      // Three core bytes to host
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      wait_wr(3, 200);
      chk("wr0", logv(0), 8'h11);
      chk("wr1", logv(1), 8'h22);
      chk("wr2", logv(2), 8'h33);
      chk("pin_protocol_a", viol, 0);

      // Both directions busy: alternation
      txe_n = 1'b1;
      push_tx(8'h61);
      push_tx(8'h62);
      push_tx(8'h63);
      repeat (4) @(negedge clk);
      seq.delete();
      host_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
      repeat (2) @(negedge clk);
      txe_n = 1'b0;
      wait_wr(6, 400);
      chk("alt0", (seq.size() > 0) ? {24'h0, seq[0]} : 32'hDEAD, "R");
      chk("alt1", (seq.size() > 1) ? {24'h0, seq[1]} : 32'hDEAD, "W");
      chk("alt2", (seq.size() > 2) ? {24'h0, seq[2]} : 32'hDEAD, "R");
      chk("alt3", (seq.size() > 3) ? {24'h0, seq[3]} : 32'hDEAD, "W");
      chk("alt_wr0", logv(3), 8'h61);
      chk("alt_wr2", logv(5), 8'h63);
      pop_rx("alt_rx0", 8'hB1);
      pop_rx("alt_rx1", 8'hB2);
      pop_rx("alt_rx2", 8'hB3);
      pop_rx("alt_rx3", 8'hB4);

      // RX back-pressure: 17 host bytes into a 16-deep FIFO
      txe_n = 1'b1;
      base  = reads;
      for (int k = 0; k < 17; k++) host_q.push_back(8'h80 + 8'(k));
      repeat (230) @(negedge clk);
      chk("rx_fill_reads", reads - base, 16);
      chk("host_left", host_q.size(), 1);
      repeat (40) @(negedge clk);
      chk("rx_full_hold", reads - base, 16);
      pop_rx("rx_full_0", 8'h80);
      repeat (40) @(negedge clk);
      chk("rx_17th_read", reads - base, 17);
      for (int k = 1; k < 17; k++) pop_rx($sformatf("rx_full_%0d", k), 8'h80 + 8'(k));

      // TX back-pressure with host not accepting
      for (int k = 0; k < 15; k++) push_tx(8'h40 + 8'(k));
      chk("tx_ready_15", tx_ready, 1);
      push_tx(8'h4F);
      chk("tx_ready_16", tx_ready, 0);
      tx_data = 8'h50; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      base  = wr_log.size();
      txe_n = 1'b0;
      wait_wr(base + 16, 400);
      repeat (40) @(negedge clk);
      chk("tx_wr_count", wr_log.size() - base, 16);
      chk("tx_wr_first", logv(base), 8'h40);
      chk("tx_wr_last", logv(base + 15), 8'h4F);
      chk("pin_protocol_b", viol, 0);

      // Asynchronous reset in the middle of a write strobe
      txe_n = 1'b1;
      push_tx(8'hC1);
      push_tx(8'hC2);
      host_q.push_back(8'h77);
      i = 0;
      while (!rx_valid && i < 100) begin @(negedge clk); i++; end
      txe_n = 1'b0;
      i = 0;
      while (wr_n && i < 100) begin @(posedge clk); #1; i++; end
      chk("wr_stb_seen", wr_n, 0);
      #3 reset = 1'b1;
      #1;
      chk("arst_wr_n", wr_n, 1);
      chk("arst_oe", pin_data_oe, 0);
      chk("arst_rx_valid", rx_valid, 0);
      chk("arst_tx_ready", tx_ready, 1);
      base = wr_log.size();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("arst_tx_flushed", wr_log.size() - base, 0);
      chk("arst_rx_flushed", rx_valid, 0);

`ifdef FT245_LOOPBACK_EN
      // Loopback: host byte is written straight back, core RX stays idle
      loopback = 1'b1;
      base = wr_log.size();
      host_q.push_back(8'h42);
      wait_wr(base + 1, 200);
      chk("lb_data", logv(base), 8'h42);
      chk("lb_rx_valid", rx_valid, 0);
      loopback = 1'b0;
`endif

      chk("pin_protocol_c", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
